// File: rtl/mod_counter_pkg.sv
// Shared constants and types for the parametrised modulo counter.
package mod_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of one counter stage; the counter is the slave side.
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             con;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;
  logic             done;

  modport master (
    output con, up, load, load_val, mode,
    input  cnt, tc, wrap, done
  );

  modport slave (
    input  con, up, load, load_val, mode,
    output cnt, tc, wrap, done
  );
endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter with load and wrap/saturate/one-shot terminal behaviour.
// tc is combinational so that stages can be chained through tc && con.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst,
  mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

  state_t           state;
  logic [WIDTH-1:0] cnt_q;
  logic             wrap_q;
  logic             done_q;
  logic             at_tc;
  logic [WIDTH-1:0] load_clamped;

  assign at_tc        = (bus.up && (cnt_q == MAX_CNT)) || (!bus.up && (cnt_q == '0));
  assign load_clamped = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;

  assign bus.cnt  = cnt_q;
  assign bus.tc   = at_tc;
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RST_CNT;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      state  <= ST_RUN;
    end else begin
      wrap_q <= 1'b0;
      if (bus.load) begin
        cnt_q  <= load_clamped;
        done_q <= 1'b0;
        state  <= ST_RUN;
      end else begin
        case (state)
          ST_RUN: begin
            if (bus.con && (bus.mode != MODE_HOLD)) begin
              if (!at_tc) begin
                cnt_q <= bus.up ? cnt_q + 1'b1 : cnt_q - 1'b1;
              end else begin
                case (bus.mode)
                  MODE_WRAP: begin
                    cnt_q  <= bus.up ? '0 : MAX_CNT;
                    wrap_q <= 1'b1;
                  end
                  MODE_ONESHOT: begin
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                  end
                  default: ;
                endcase
              end
            end
          end
          ST_DONE: begin
            // Any mode other than one-shot releases the counter; cnt is kept.
            if (bus.mode != MODE_ONESHOT) begin
              done_q <= 1'b0;
              state  <= ST_RUN;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench: two cascaded MODULUS=10 counters against an arithmetic model.
module tb_mod_counter;

  localparam int M = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(4)) lo_if ();
  mod_counter_if #(.WIDTH(4)) hi_if ();

  mod_counter #(.WIDTH(4), .MODULUS(M), .RST_VAL(0)) u_lo (.clk(clk), .rst(rst), .bus(lo_if));
  mod_counter #(.WIDTH(4), .MODULUS(M), .RST_VAL(0)) u_hi (.clk(clk), .rst(rst), .bus(hi_if));

  assign hi_if.con      = lo_if.tc && lo_if.con;
  assign hi_if.up       = 1'b1;
  assign hi_if.load     = 1'b0;
  assign hi_if.load_val = 4'd0;
  assign hi_if.mode     = 2'b00;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_cnt = 0;
  bit m_wrap = 0;
  bit m_done = 0;
  int m_hi = 0;

  task automatic tick(bit r, bit c, bit u, bit l, int lv, bit [1:0] md);
    bit term;
    bit hi_step;
    rst = r; lo_if.con = c; lo_if.up = u; lo_if.load = l;
    lo_if.load_val = 4'(lv); lo_if.mode = md;
    term    = u ? (m_cnt == M - 1) : (m_cnt == 0);
    hi_step = c && term;
    @(posedge clk);
    m_wrap = 0;
    if (r) begin
      m_cnt = 0; m_done = 0; m_hi = 0;
    end else begin
      if (hi_step) m_hi = (m_hi + 1) % M;
      if (l) begin
        m_cnt = (lv > M - 1) ? M - 1 : lv; m_done = 0;
      end else if (m_done) begin
        if (md != 2'b10) m_done = 0;
      end else if (c && md != 2'b11) begin
        if (!term || md == 2'b00) begin
          m_cnt  = (m_cnt + (u ? 1 : M - 1)) % M;
          m_wrap = term;
        end else if (md == 2'b10) m_done = 1;
      end
    end
    #1;
  endtask

  function automatic bit model_tc();
    return lo_if.up ? (m_cnt == M - 1) : (m_cnt == 0);
  endfunction

  task automatic test_reset();
    tick(1, 0, 1, 0, 0, 2'b00);
    n_checks++;
    if (lo_if.cnt !== 4'd0 || lo_if.wrap !== 1'b0 || lo_if.done !== 1'b0 || hi_if.cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: cnt=%0d wrap=%0b done=%0b hi=%0d, expected 0 0 0 0",
               lo_if.cnt, lo_if.wrap, lo_if.done, hi_if.cnt);
    end
  endtask

  task automatic test_wrap_up();
    for (int i = 1; i <= 12; i++) begin
      tick(0, 1, 1, 0, 0, 2'b00);
      n_checks++;
      if (lo_if.cnt !== 4'(i % M) || lo_if.wrap !== (i == 10) || lo_if.tc !== ((i % M) == 9)) begin
        n_fail++;
        $display("FAIL wrap_up step %0d: cnt=%0d wrap=%0b tc=%0b, expected %0d %0b %0b",
                 i, lo_if.cnt, lo_if.wrap, lo_if.tc, i % M, i == 10, (i % M) == 9);
      end
    end
  endtask

  task automatic test_down_and_rst();
    int exp_seq[5] = '{9, 8, 7, 6, 5};
    tick(1, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, 0, 0, 2'b00);
      n_checks++;
      if (lo_if.cnt !== 4'(exp_seq[i]) || lo_if.wrap !== (i == 0)) begin
        n_fail++;
        $display("FAIL down step %0d: cnt=%0d wrap=%0b, expected %0d %0b",
                 i, lo_if.cnt, lo_if.wrap, exp_seq[i], i == 0);
      end
    end
    tick(1, 1, 0, 0, 0, 2'b00);
    n_checks++;
    if (lo_if.cnt !== 4'd0 || lo_if.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: cnt=%0d wrap=%0b, expected 0 0", lo_if.cnt, lo_if.wrap);
    end
  endtask

  task automatic test_saturate();
    int exp_seq[5] = '{8, 9, 9, 9, 8};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) tick(0, 1, 1, 1, 8, 2'b01);
      else        tick(0, 1, (i < 4), 0, 0, 2'b01);
      n_checks++;
      if (lo_if.cnt !== 4'(exp_seq[i]) || lo_if.wrap !== 1'b0 || lo_if.cnt !== 4'(m_cnt)) begin
        n_fail++;
        $display("FAIL saturate step %0d: cnt=%0d wrap=%0b, expected %0d 0",
                 i, lo_if.cnt, lo_if.wrap, exp_seq[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    tick(0, 0, 1, 1, 7, 2'b10);
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, (i < 3) ? 1'b1 : 1'($urandom_range(0, 1)), 0, 0, 2'b10);
      n_checks++;
      if (lo_if.cnt !== 4'((i == 0) ? 8 : 9) || lo_if.done !== (i >= 2) || lo_if.wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot step %0d: cnt=%0d done=%0b wrap=%0b, expected %0d %0b 0",
                 i, lo_if.cnt, lo_if.done, lo_if.wrap, (i == 0) ? 8 : 9, i >= 2);
      end
    end
    tick(0, 1, 1, 1, 15, 2'b10);
    n_checks++;
    if (lo_if.cnt !== 4'd9 || lo_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp: cnt=%0d done=%0b, expected 9 0", lo_if.cnt, lo_if.done);
    end
    tick(0, 1, 1, 0, 0, 2'b10);
    tick(0, 1, 1, 0, 0, 2'b00);
    n_checks++;
    if (lo_if.cnt !== 4'd9 || lo_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL leave_done: cnt=%0d done=%0b, expected 9 0", lo_if.cnt, lo_if.done);
    end
    tick(0, 1, 1, 0, 0, 2'b00);
    n_checks++;
    if (lo_if.cnt !== 4'd0 || lo_if.wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: cnt=%0d wrap=%0b, expected 0 1", lo_if.cnt, lo_if.wrap);
    end
  endtask

  task automatic test_load_hold_toggle();
    int exp_c;
    tick(0, 0, 1, 1, 6, 2'b00);
    tick(0, 1, 1, 1, 3, 2'b00);
    n_checks++;
    if (lo_if.cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL load_wins: cnt=%0d expected 3", lo_if.cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1, 0, 0, 2'b11);
      n_checks++;
      if (lo_if.cnt !== 4'd3 || lo_if.wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL hold: cnt=%0d wrap=%0b, expected 3 0", lo_if.cnt, lo_if.wrap);
      end
    end
    exp_c = 3;
    for (int i = 0; i < 8; i++) begin
      tick(0, i[0], 1, 0, 0, 2'b00);
      if (i[0]) exp_c++;
      n_checks++;
      if (lo_if.cnt !== 4'(exp_c)) begin
        n_fail++;
        $display("FAIL con_toggle %0d: cnt=%0d expected %0d", i, lo_if.cnt, exp_c);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      n_checks++;
      if (lo_if.cnt !== 4'(m_cnt) || lo_if.wrap !== m_wrap || lo_if.done !== m_done ||
          lo_if.tc !== model_tc() || hi_if.cnt !== 4'(m_hi)) begin
        n_fail++;
        $display("FAIL random %0d: cnt=%0d wrap=%0b done=%0b tc=%0b hi=%0d, expected %0d %0b %0b %0b %0d",
                 i, lo_if.cnt, lo_if.wrap, lo_if.done, lo_if.tc, hi_if.cnt,
                 m_cnt, m_wrap, m_done, model_tc(), m_hi);
      end
    end
  endtask

  task automatic test_cascade();
    tick(1, 0, 1, 0, 0, 2'b00);
    for (int i = 1; i <= 25; i++) begin
      tick(0, 1, 1, 0, 0, 2'b00);
      n_checks++;
      if (hi_if.cnt !== 4'(i / M) || lo_if.cnt !== 4'(i % M)) begin
        n_fail++;
        $display("FAIL cascade %0d: hi=%0d lo=%0d, expected %0d %0d",
                 i, hi_if.cnt, lo_if.cnt, i / M, i % M);
      end
    end
    n_checks++;
    if ({hi_if.cnt, lo_if.cnt} !== 8'h25) begin
      n_fail++;
      $display("FAIL cascade_final: got %h, expected 25", {hi_if.cnt, lo_if.cnt});
    end
  endtask

  initial begin
    lo_if.con = 0; lo_if.up = 1; lo_if.load = 0; lo_if.load_val = 0; lo_if.mode = 2'b00;
    test_reset();
    test_wrap_up();
    test_down_and_rst();
    test_saturate();
    test_oneshot();
    test_load_hold_toggle();
    test_random();
    test_cascade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
